gatelogic_seq_checker: RTL and testbench
========================================

Name: gatelogic_seq_checker

Overview:
- Self-running stimulus/check stage wrapped around the gatelogic 2:1 select cell.
- Upstream role: drives a/b/s through all 8 input combinations, one vector per hold window.
- Downstream role: samples z at the end of each window, compares it with the expected value (s ? b : a), and reports pass/fail, error count and first failing vector.
- Replaces the hand-written delay stimulus with a clocked, synthesizable sequence usable on the board.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held; legal range 2..255; z is sampled on the last cycle of each hold.
- CNT_W, 8, width of the hold counter; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a run; ignored while busy=1.
- z_in  input  1  output of the gatelogic instance under check.
- a_out  output  1  drives gatelogic input a.
- b_out  output  1  drives gatelogic input b.
- s_out  output  1  drives gatelogic select s.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start; sticky.
- pass  output  1  valid while done=1; 1 when err_cnt==0.
- err_cnt  output  4  number of mismatching vectors, range 0..8.
- first_err_valid  output  1  set at the first mismatch of the run.
- first_err_idx  output  3  index of the first mismatching vector; valid while first_err_valid=1.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; every output, vector index and hold counter forced to 0.
- Reset mid-run: run is abandoned, no done is produced, all results are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last sample of vector 7--> DONE.
  - DONE --start--> RUN.
- On an accepted start (edge k):
  - err_cnt, first_err_valid, first_err_idx, done, pass, vector index and hold counter are cleared.
  - busy=1 from cycle k+1.
  - Vector 0 is driven from cycle k+1.
- Vector encoding for index i (0..7): s_out=i[2], a_out=i[1], b_out=i[0]. All three change on the same edge.
- Expected z per index: 0,0,1,1,0,1,0,1.
- Hold counter runs 0..HOLD_CYCLES-1 per vector.
  - z_in is compared only when the counter equals HOLD_CYCLES-1. Values of z_in before that point are ignored (settling window).
  - The same edge advances the index (or ends the run after index 7) and resets the counter.
- On a mismatch: err_cnt increments. If first_err_valid=0, first_err_valid is set to 1 and first_err_idx is set to i.
- Run length is exactly 8*HOLD_CYCLES cycles of busy=1.
- On the cycle after the final sample:
  - busy=0, done=1.
  - pass=(err_cnt==0), computed including the final compare.
  - a_out/b_out/s_out return to 0.
- In IDLE and DONE, a_out/b_out/s_out are held at 0.
- start while busy=1 has no effect.
- start in DONE restarts the run and clears done in the same edge.
- err_cnt cannot exceed 8, so no saturation logic is required.
- z_in is registered once before the compare. The sample point accounts for this extra stage, so the compare uses z from cycle HOLD_CYCLES-1 of the current vector.

Test Plan:
- Ideal mux model (z=s?b:a), HOLD_CYCLES=4, start pulse -> busy high for 32 cycles; then done=1, pass=1, err_cnt=0, first_err_valid=0.
- z_in stuck at 0 -> err_cnt=4 (indices 2,3,5,7), first_err_idx=2, pass=0.
- z_in stuck at 1 -> err_cnt=4 (indices 0,1,4,6), first_err_idx=0, pass=0.
- Swapped-select model (z=s?a:b) -> err_cnt=4 (indices 1,2,5,6), first_err_idx=1, pass=0.
- Ideal model with z forced wrong for the first HOLD_CYCLES-1 cycles of every vector -> pass=1; start re-pulsed at cycle 10 of the run -> ignored, run still ends at cycle 32.
- reset_n low at cycle 13 of a stuck-0 run -> all outputs 0 immediately; after release, a new start gives a full run with correct results and no residue from the aborted run.

Source files
------------

// File: rtl/gatelogic_seq_checker.sv
// gatelogic_seq_checker: clocked self-test for the gatelogic 2:1 select cell.
// Walks all 8 {s,a,b} vectors, samples z at the end of each hold, tallies errors.
module gatelogic_seq_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       s_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       first_err_valid,
  output logic [2:0] first_err_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             LAST_I   = HOLD_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];
  localparam int             ONE_I    = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = ONE_I[CNT_W-1:0];

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [3:0]       err_q, err_d;
  logic             fev_q, fev_d;
  logic [2:0]       fei_q, fei_d;
  logic             z_q;
  logic             chk_q, chk_d;
  logic [2:0]       chk_idx_q, chk_idx_d;
  logic             exp_q, exp_d;

  logic accept;
  logic mis;

  // z is captured on the last hold cycle and judged one cycle later;
  // the pending verdict is merged into the outputs combinationally.
  assign mis    = chk_q & (z_q ^ exp_q);
  assign accept = start & (state_q != S_RUN);

  // Next-state: sequencing, hold counting and result accumulation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fei_d     = fei_q;
    chk_d     = 1'b0;
    chk_idx_d = chk_idx_q;
    exp_d     = exp_q;

    if (mis) begin
      err_d = err_q + 4'd1;
      if (!fev_q) begin
        fev_d = 1'b1;
        fei_d = chk_idx_q;
      end
    end

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          chk_d     = 1'b1;
          chk_idx_d = idx_q;
          exp_d     = idx_q[2] ? idx_q[0] : idx_q[1];
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = S_RUN;
      idx_d   = 3'd0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 4'd0;
      fev_d   = 1'b0;
      fei_d   = 3'd0;
      chk_d   = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 4'd0;
      fev_q     <= 1'b0;
      fei_q     <= 3'd0;
      z_q       <= 1'b0;
      chk_q     <= 1'b0;
      chk_idx_q <= 3'd0;
      exp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fev_q     <= fev_d;
      fei_q     <= fei_d;
      z_q       <= z_in;
      chk_q     <= chk_d;
      chk_idx_q <= chk_idx_d;
      exp_q     <= exp_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign s_out = busy & idx_q[2];
  assign a_out = busy & idx_q[1];
  assign b_out = busy & idx_q[0];
  assign done  = done_q;

  assign err_cnt         = err_q + {3'b000, mis};
  assign first_err_valid = fev_q | mis;
  assign first_err_idx   = fev_q ? fei_q : (mis ? chk_idx_q : 3'd0);
  assign pass            = done_q & (err_cnt == 4'd0);

endmodule

// File: tb/tb_gatelogic_seq_checker.sv
// tb_gatelogic_seq_checker: table, random-fault and corner-case runs
// against a vector-level model of the select-cell self test.
module tb_gatelogic_seq_checker;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       z_in = 1'b0;
  logic       a_out, b_out, s_out;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic       first_err_valid;
  logic [2:0] first_err_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gatelogic_seq_checker #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .z_in(z_in),
    .a_out(a_out),
    .b_out(b_out),
    .s_out(s_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx)
  );

  typedef struct {
    string      name;
    int         mode;
    int         restart_at;
    int         exp_err;
    bit         exp_fev;
    int         exp_fei;
    bit         exp_pass;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behaviour of the cell under check for each fault mode.
  // pos is the cycle within the hold window (0..H-1).
  function automatic logic cell_z(input int mode, input logic [7:0] mask,
                                  input logic [2:0] v, input int pos);
    logic ideal;
    logic last;
    ideal = v[2] ? v[0] : v[1];
    last  = (pos == H - 1);
    case (mode)
      0: return ideal;
      1: return 1'b0;
      2: return 1'b1;
      3: return v[2] ? v[1] : v[0];
      4: return last ? ideal : ~ideal;
      default: return last ? (ideal ^ mask[v]) : 1'($urandom);
    endcase
  endfunction

  task automatic outs_zero(input string name);
    chk(name, int'({a_out, b_out, s_out, busy, done, pass,
                    err_cnt, first_err_valid, first_err_idx}), 0);
  endtask

  task automatic check_result(input string name, input int e_err,
                              input bit e_fev, input int e_fei, input bit e_pass);
    chk({name, "_err_cnt"}, int'(err_cnt), e_err);
    chk({name, "_fev"}, int'(first_err_valid), int'(e_fev));
    if (e_fev) chk({name, "_fei"}, int'(first_err_idx), e_fei);
    chk({name, "_pass"}, int'(pass), int'(e_pass));
  endtask

  task automatic do_run(input int mode, input logic [7:0] mask,
                        input int restart_at, input int reset_at,
                        output bit aborted);
    logic [2:0] v;
    aborted = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 8 * H; c++) begin
      v     = {s_out, a_out, b_out};
      z_in  = cell_z(mode, mask, v, (c - 1) % H);
      start = (c == restart_at);
      if (c == reset_at) begin
        reset_n = 1'b0;
        #1;
        outs_zero("reset_mid_run");
        @(posedge clk); @(posedge clk);
        #1 reset_n = 1'b1;
        start   = 1'b0;
        aborted = 1'b1;
        return;
      end
      @(negedge clk);
      if (c == 1)
        chk("start_clears", int'({done, err_cnt, first_err_valid}), 0);
      chk("busy_in_run", int'(busy), 1);
      chk("vector", int'({s_out, a_out, b_out}), (c - 1) / H);
      @(posedge clk); #1;
    end
    start = 1'b0;
    z_in  = 1'b0;
    @(negedge clk);
    chk("run_end", int'({busy, done, s_out, a_out, b_out}), 5'b01000);
  endtask

  initial begin
    bit         ab;
    logic [7:0] mask;
    int         e_err;
    int         e_fei;

    tbl[0] = '{"ideal",    0, 0,  0, 1'b0, 0, 1'b1};
    tbl[1] = '{"stuck0",   1, 0,  4, 1'b1, 2, 1'b0};
    tbl[2] = '{"stuck1",   2, 0,  4, 1'b1, 0, 1'b0};
    tbl[3] = '{"swapped",  3, 0,  4, 1'b1, 1, 1'b0};
    tbl[4] = '{"settle",   4, 10, 0, 1'b0, 0, 1'b1};

    #1;
    outs_zero("reset_state");
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    outs_zero("idle_after_reset");

    for (int i = 0; i < 5; i++) begin
      do_run(tbl[i].mode, 8'h00, tbl[i].restart_at, 0, ab);
      check_result(tbl[i].name, tbl[i].exp_err, tbl[i].exp_fev,
                   tbl[i].exp_fei, tbl[i].exp_pass);
    end

    // Reset in the middle of a stuck-0 run, then a clean run.
    do_run(1, 8'h00, 0, 13, ab);
    chk("aborted_flag", int'(ab), 1);
    @(negedge clk);
    outs_zero("idle_after_abort");
    do_run(0, 8'h00, 0, 0, ab);
    check_result("after_abort", 0, 1'b0, 0, 1'b1);

    // Random per-vector faults; junk on z during every settle window.
    for (int r = 0; r < 12; r++) begin
      if (r == 0)      mask = 8'h00;
      else if (r == 1) mask = 8'hFF;
      else if (r == 2) mask = 8'h80;
      else             mask = 8'($urandom);
      e_err = $countones(mask);
      e_fei = 0;
      for (int b = 7; b >= 0; b--)
        if (mask[b]) e_fei = b;
      do_run(5, mask, 0, 0, ab);
      check_result($sformatf("rand_%02h", mask), e_err, mask != 8'h00,
                   e_fei, mask == 8'h00);
    end

    // Results stay sticky in DONE without a new start.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("done_sticky", int'({done, busy}), 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
